// File: rtl/ets_anomaly_logger_pkg.sv
// Shared widths, saturation limits and the packed log entry for the ETS anomaly logger.
// ETS_LOG_TIMESTAMP_EN adds a cycle timestamp field to each entry.
package ets_pkg;
  localparam int ETS_DELTA_W = 32;
  localparam int ETS_PC_W    = 32;
  localparam int ETS_TS_W    = 32;
  localparam int ETS_DROP_W  = 16;
  localparam int ETS_TOTAL_W = 32;

  localparam logic [ETS_DROP_W-1:0]  ETS_DROP_MAX  = '1;
  localparam logic [ETS_TOTAL_W-1:0] ETS_TOTAL_MAX = '1;

  typedef struct packed {
    logic [ETS_PC_W-1:0]           pc;
    logic signed [ETS_DELTA_W-1:0] delta;
    logic                          slow;
    logic                          fast;
`ifdef ETS_LOG_TIMESTAMP_EN
    logic [ETS_TS_W-1:0]           ts;
`endif
  } ets_log_entry_t;
endpackage

// File: rtl/ets_anomaly_logger_if.sv
// Event, control, read-port and status bundle of the ETS anomaly logger.
interface ets_anomaly_logger_if import ets_pkg::*; #(parameter int DEPTH = 8) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   log_enable, anomaly_detected, too_slow, too_fast;
  logic [ETS_DELTA_W-1:0] timing_delta;
  logic [ETS_PC_W-1:0]    event_pc;
  logic                   flush, clear_stats, irq_enable, rd_ready;
  logic                   rd_valid, rd_slow, rd_fast, overflow, irq;
  logic [ETS_PC_W-1:0]    rd_pc;
  logic [ETS_DELTA_W-1:0] rd_delta;
  logic [ETS_TS_W-1:0]    rd_timestamp;
  logic [CW-1:0]          fifo_count;
  logic [ETS_DROP_W-1:0]  dropped_count;
  logic [ETS_TOTAL_W-1:0] total_count;

  modport slave (
    input  log_enable, anomaly_detected, too_slow, too_fast, timing_delta, event_pc,
           flush, clear_stats, irq_enable, rd_ready,
    output rd_valid, rd_pc, rd_delta, rd_slow, rd_fast, rd_timestamp,
           fifo_count, dropped_count, total_count, overflow, irq
  );
  modport master (
    output log_enable, anomaly_detected, too_slow, too_fast, timing_delta, event_pc,
           flush, clear_stats, irq_enable, rd_ready,
    input  rd_valid, rd_pc, rd_delta, rd_slow, rd_fast, rd_timestamp,
           fifo_count, dropped_count, total_count, overflow, irq
  );
endinterface

// File: rtl/ets_log_fifo.sv
// First-word-fall-through FIFO with flush; also exposes next-cycle occupancy.
module ets_log_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              wdata_i,
  output T              rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o
);
  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
endmodule

// File: rtl/ets_anomaly_logger.sv
// ETS anomaly logger: captures qualified timing anomalies into a FIFO, keeps saturating
// stats and a level irq. ETS_LOG_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module ets_anomaly_logger import ets_pkg::*; #(
  parameter int DEPTH         = 8,
  parameter int IRQ_THRESHOLD = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ets_anomaly_logger_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  ets_log_entry_t         wr_entry, rd_entry;
  logic                   qual, pop, push, drop, full, empty;
  logic [CW-1:0]          count, count_nxt;
  logic [ETS_TOTAL_W-1:0] total_q, total_d;
  logic [ETS_DROP_W-1:0]  dropped_q, dropped_d;
  logic                   overflow_q, overflow_d, irq_q, irq_d;

  assign qual = bus.anomaly_detected && bus.log_enable;
  assign pop  = !empty && bus.rd_ready;
  // flush wins: a same-cycle event is neither stored nor counted as a drop
  assign push = qual && !bus.flush && (!full || pop);
  assign drop = qual && !bus.flush && full && !pop;

  assign wr_entry.pc    = bus.event_pc;
  assign wr_entry.delta = bus.timing_delta;
  assign wr_entry.slow  = bus.too_slow;
  assign wr_entry.fast  = bus.too_fast;

`ifdef ETS_LOG_TIMESTAMP_EN
  logic [ETS_TS_W-1:0] ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + ETS_TS_W'(1);
  end
  assign wr_entry.ts      = ts_q;
  assign bus.rd_timestamp = empty ? '0 : rd_entry.ts;
`else
  assign bus.rd_timestamp = '0;
`endif

  ets_log_fifo #(.DEPTH(DEPTH), .T(ets_log_entry_t)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (bus.flush),
    .wdata_i    (wr_entry),
    .rdata_o    (rd_entry),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .count_nxt_o(count_nxt)
  );

  // clear first, then apply this cycle's event so a coincident event/drop survives the clear
  always_comb begin
    total_d    = total_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    if (bus.clear_stats) begin
      total_d    = '0;
      dropped_d  = '0;
      overflow_d = 1'b0;
    end
    if (qual && total_d != ETS_TOTAL_MAX) total_d = total_d + ETS_TOTAL_W'(1);
    if (drop) begin
      if (dropped_d != ETS_DROP_MAX) dropped_d = dropped_d + ETS_DROP_W'(1);
      overflow_d = 1'b1;
    end
    irq_d = bus.irq_enable && ((count_nxt >= CW'(IRQ_THRESHOLD)) || overflow_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      total_q    <= total_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_valid      = !empty;
  assign bus.rd_pc         = empty ? '0 : rd_entry.pc;
  assign bus.rd_delta      = empty ? '0 : rd_entry.delta;
  assign bus.rd_slow       = !empty && rd_entry.slow;
  assign bus.rd_fast       = !empty && rd_entry.fast;
  assign bus.fifo_count    = count;
  assign bus.dropped_count = dropped_q;
  assign bus.total_count   = total_q;
  assign bus.overflow      = overflow_q;
  assign bus.irq           = irq_q;
endmodule

// File: tb/tb_ets_anomaly_logger.sv
// Scoreboard bench for ets_anomaly_logger: stimulus queues expected entries, a monitor checks pops.
module tb_ets_anomaly_logger;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ets_anomaly_logger_if #(.DEPTH(8)) bus ();
  ets_anomaly_logger #(.DEPTH(8), .IRQ_THRESHOLD(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] delta;
    logic        slow;
    logic        fast;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tcnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0;
    else        tcnt <= tcnt + 1;

  function automatic logic [31:0] ts_of(input logic [31:0] c);
`ifdef ETS_LOG_TIMESTAMP_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [31:0] d, input logic s, input logic f,
                    input bit push_exp);
    exp_t e;
    bus.anomaly_detected = 1'b1;
    bus.event_pc = pc; bus.timing_delta = d; bus.too_slow = s; bus.too_fast = f;
    if (push_exp) begin
      e.pc = pc; e.delta = d; e.slow = s; e.fast = f; e.ts = ts_of(tcnt);
      sb.push_back(e);
    end
    step();
    bus.anomaly_detected = 1'b0; bus.too_slow = 1'b0; bus.too_fast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rd_ready = 1'b1;
    while (bus.fifo_count != 0 && n < 40) begin
      step();
      n++;
    end
    bus.rd_ready = 1'b0;
    chk("drain_timeout", 64'(n < 40), 1);
    chk("sb_empty_after_drain", sb.size(), 0);
  endtask

  // monitor: every accepted head entry must match the scoreboard front
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rd_valid && bus.rd_ready) begin
        if (sb.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rd_pc", bus.rd_pc, e.pc);
          chk("rd_delta", bus.rd_delta, e.delta);
          chk("rd_class", {bus.rd_slow, bus.rd_fast}, {e.slow, e.fast});
          chk("rd_timestamp", bus.rd_timestamp, e.ts);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.log_enable = 1'b1; bus.anomaly_detected = 1'b0; bus.too_slow = 1'b0; bus.too_fast = 1'b0;
    bus.timing_delta = '0; bus.event_pc = '0; bus.flush = 1'b0; bus.clear_stats = 1'b0;
    bus.irq_enable = 1'b1; bus.rd_ready = 1'b0;
    repeat (3) step();
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_dropped", bus.dropped_count, 0);
    chk("rst_total", bus.total_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_timestamp", bus.rd_timestamp, 0);
    rst_n = 1'b1;

    // timestamps: events at cycles 5 and 12 after reset release
    while (tcnt != 5) step();
    ev(32'h50, 32'd1, 1'b1, 1'b0, 1);
    while (tcnt != 12) step();
    ev(32'h60, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    chk("ts_head", bus.rd_timestamp, ts_of(5));
    drain();

    // three in-order events, first-word-fall-through latency
    bus.anomaly_detected = 1'b1; bus.event_pc = 32'h100; bus.timing_delta = 32'd20; bus.too_slow = 1'b1;
    sb.push_back('{32'h100, 32'd20, 1'b1, 1'b0, ts_of(tcnt)});
    @(negedge clk);
    chk("lat_before", bus.rd_valid, 0);
    step();
    bus.anomaly_detected = 1'b0; bus.too_slow = 1'b0;
    @(negedge clk);
    chk("lat_after", bus.rd_valid, 1);
    chk("lat_count", bus.fifo_count, 1);
    chk("irq_threshold", bus.irq, 1);
    step();
    ev(32'h104, 32'hFFFF_FFF1, 1'b0, 1'b1, 1);
    ev(32'h108, 32'd9, 1'b1, 1'b1, 1);
    chk("count_3", bus.fifo_count, 3);
    drain();
    chk("count_0", bus.fifo_count, 0);

    // fill past full: 8 stored, 2 dropped
    bus.clear_stats = 1'b1; step(); bus.clear_stats = 1'b0;
    chk("clear_total", bus.total_count, 0);
    for (int i = 0; i < 10; i++) ev(32'h200 + 32'(4 * i), 32'(i), 1'b1, 1'b0, i < 8);
    chk("full_count", bus.fifo_count, 8);
    chk("full_dropped", bus.dropped_count, 2);
    chk("full_overflow", bus.overflow, 1);
    chk("full_irq", bus.irq, 1);
    chk("full_total", bus.total_count, 10);

    // full + event + pop in one cycle: no drop, new entry goes last
    bus.rd_ready = 1'b1;
    ev(32'h300, 32'd77, 1'b0, 1'b1, 1);
    bus.rd_ready = 1'b0;
    chk("pushpop_count", bus.fifo_count, 8);
    chk("pushpop_dropped", bus.dropped_count, 2);
    drain();
    chk("irq_overflow_hold", bus.irq, 1);

    // flush with a same-cycle event and 4 entries queued
    for (int i = 0; i < 4; i++) ev(32'h400 + 32'(4 * i), 32'd3, 1'b1, 1'b0, 1);
    bus.flush = 1'b1;
    ev(32'h500, 32'd5, 1'b1, 1'b0, 0);
    bus.flush = 1'b0;
    sb.delete();
    chk("flush_count", bus.fifo_count, 0);
    chk("flush_valid", bus.rd_valid, 0);
    chk("flush_dropped", bus.dropped_count, 2);
    chk("flush_total", bus.total_count, 16);

    // clear_stats with overflow set, FIFO empty
    bus.clear_stats = 1'b1; step(); bus.clear_stats = 1'b0;
    chk("clr_dropped", bus.dropped_count, 0);
    chk("clr_overflow", bus.overflow, 0);
    chk("clr_total", bus.total_count, 0);
    chk("clr_irq", bus.irq, 0);

    // irq masked
    bus.irq_enable = 1'b0;
    ev(32'h600, 32'd1, 1'b0, 1'b0, 1);
    chk("irq_masked", bus.irq, 0);
    drain();
    bus.irq_enable = 1'b1;

    // clear_stats coincident with a drop
    for (int i = 0; i < 8; i++) ev(32'h700 + 32'(4 * i), 32'd2, 1'b0, 1'b1, 1);
    bus.clear_stats = 1'b1;
    ev(32'h800, 32'd8, 1'b1, 1'b0, 0);
    bus.clear_stats = 1'b0;
    chk("clrdrop_dropped", bus.dropped_count, 1);
    chk("clrdrop_overflow", bus.overflow, 1);
    chk("clrdrop_total", bus.total_count, 1);

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.rd_valid, 0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_dropped", bus.dropped_count, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_irq", bus.irq, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("sb_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
